// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry skid register for a valid/ready pipeline stage (e.g. the fetch
// stage, where the payload is {PC, instruction}). The main entry always drives
// out_data; the skid entry catches the one extra payload that can arrive while
// the downstream stalls. in_ready is decoded from registered state plus the
// stage-wide freeze/flush controls only, so there is no combinational path
// from out_ready to in_ready.
//
// Parameters
//   DATA_W     payload width
//   CNT_W      width of the saturating stall counter
//   FLUSH_VAL  payload loaded into both entries on flush and reset
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of all held entries (has priority over freeze)
//   freeze     synchronous hold; blocks both transfers
//   in_valid   upstream presents in_data
//   in_ready   block can accept in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data is valid for downstream
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload held in the main entry
//   stall_cnt  saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                DATA_W    = 64,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  stall_q;

    logic in_fire;
    logic out_fire;
    logic stalled;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (&v)
            return v;
        else
            return v + one;
    endfunction

    // reset is gated in so that in_ready reads 0 for the whole time reset is
    // held; state is already EMPTY then, which alone would advertise ready.
    assign in_ready  = ~reset & (state != FULL) & ~freeze & ~flush;
    assign out_valid = (state != EMPTY) & ~freeze;
    assign out_data  = main_data;
    assign stall_cnt = stall_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stalled  = out_valid & ~out_ready;

    // Entry/state machine. Flush wins over freeze and over any incoming
    // payload; freeze already zeroes both fires, the explicit hold branch
    // just makes that intent visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
        end else if (flush) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
        end else if (freeze) begin
            state     <= state;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // Pass-through: the old main leaves, the new payload
                        // takes its place, skid stays untouched.
                        main_data <= in_data;
                    end else if (in_fire) begin
                        skid_data <= in_data;
                        state     <= FULL;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low in FULL, so only the drain can happen.
                    if (out_fire) begin
                        main_data <= skid_data;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Back-pressure counter: independent of flush/freeze except through
    // out_valid itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (stalled)
            stall_q <= sat_inc(stall_q);
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Bench for pipe_skid_reg with a small counter (CNT_W=4) and a recognisable
// FLUSH_VAL. A negedge monitor keeps a FIFO scoreboard: accepted payloads are
// pushed, delivered payloads are popped and compared against out_data. Flush
// and reset empty the scoreboard. Directed sequences cover streaming,
// back-pressure, flush, freeze, asynchronous reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int              DATA_W = 16;
    localparam int              CNT_W  = 4;
    localparam logic [DATA_W-1:0] FVAL = 16'hDEAD;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              freeze;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks;
    int failures;
    int clr_gen;
    int seen_gen;
    logic [DATA_W-1:0] exp_q[$];

    pipe_skid_reg #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .FLUSH_VAL(FVAL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .freeze   (freeze),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor. Inputs are driven 1 time unit after the rising
    // edge, so at the falling edge they show what the next edge will do.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (clr_gen != seen_gen) begin
            exp_q.delete();
            seen_gen = clr_gen;
        end
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(in_data);
            if (flush)
                exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clr_gen   = 0;
        seen_gen  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        freeze    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state while reset is held
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'(FVAL));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        step();
        reset = 1'b0;
        clr_gen++;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Streaming 1..4 with out_ready high
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("strm_in_ready", 32'(in_ready), 32'd1);
            send(DATA_W'(i));
            chk("strm_out_valid", 32'(out_valid), 32'd1);
            chk("strm_out_data",  32'(out_data),  32'(i));
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        step();
        chk("strm_drain_valid", 32'(out_valid), 32'd0);
        chk("strm_stall_cnt",   32'(stall_cnt), 32'd0);

        // Back-pressure: A then B with out_ready low
        out_ready = 1'b0;
        send(16'hA0A0);
        chk("bp_stall0", 32'(stall_cnt), 32'd0);
        send(16'hB0B0);
        chk("bp_full_in_ready", 32'(in_ready),  32'd0);
        chk("bp_out_data_a",    32'(out_data),  32'hA0A0);
        chk("bp_stall1",        32'(stall_cnt), 32'd1);
        step();
        chk("bp_stall2",        32'(stall_cnt), 32'd2);
        chk("bp_hold_a",        32'(out_data),  32'hA0A0);
        out_ready = 1'b1;
        step();
        chk("bp_out_data_b",    32'(out_data),  32'hB0B0);
        chk("bp_in_ready_one",  32'(in_ready),  32'd1);
        step();
        chk("bp_empty",         32'(out_valid), 32'd0);
        chk("bp_stall_held",    32'(stall_cnt), 32'd2);

        // Flush while FULL with C offered on the input
        out_ready = 1'b0;
        send(16'hE0E0);
        send(16'hF0F0);
        chk("fl_full", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hC0C0;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data",  32'(out_data),  32'(FVAL));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_c", 32'(out_valid), 32'd0);
        end

        // Freeze while ONE holding D
        out_ready = 1'b0;
        send(16'hD0D0);
        freeze    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hBAD1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_out_valid", 32'(out_valid), 32'd0);
            chk("frz_in_ready",  32'(in_ready),  32'd0);
            chk("frz_out_data",  32'(out_data),  32'hD0D0);
            step();
        end
        freeze   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("frz_rel_valid", 32'(out_valid), 32'd1);
        chk("frz_rel_data",  32'(out_data),  32'hD0D0);
        step();
        chk("frz_delivered", 32'(out_valid), 32'd0);

        // Asynchronous reset pulse between edges while FULL
        out_ready = 1'b0;
        send(16'h1111);
        send(16'h2222);
        chk("ar_full",     32'(in_ready), 32'd0);
        chk("ar_pre_data", 32'(out_data), 32'h1111);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd0);
        chk("ar_out_data",  32'(out_data),  32'(FVAL));
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
        clr_gen++;
        reset = 1'b0;
        #1;
        chk("ar_rel_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        step();
        chk("ar_no_stale", 32'(out_valid), 32'd0);

        // Stall counter saturation at 2^CNT_W-1
        out_ready = 1'b0;
        send(16'h5A5A);
        for (int i = 0; i < 20; i++)
            step();
        chk("sat_15", 32'(stall_cnt), 32'd15);
        step();
        step();
        chk("sat_held", 32'(stall_cnt), 32'd15);
        out_ready = 1'b1;
        step();
        chk("sat_after_drain", 32'(stall_cnt), 32'd15);
        step();
        step();
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, sets the payload width; for the fetch stage the payload is {PC, instruction}.
REQ-002 Parameter CNT_W, default 16, sets the width of the stall counter.
REQ-003 Parameter FLUSH_VAL, default all-zero (DATA_W bits), is the payload loaded into both entries on flush and reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries (branch taken / mispredict).
REQ-007 freeze  input  1  synchronous hold (hazard stall); blocks both transfers.
REQ-008 in_valid  input  1  upstream presents in_data.
REQ-009 in_ready  output  1  block can accept in_data this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  out_data is valid for downstream.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  DATA_W  payload held in the main entry.
REQ-014 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 The block SHALL hold two entries, main and skid, tracked by the states EMPTY (none valid), ONE (main valid) and FULL (main and skid valid).
REQ-016 in_ready SHALL equal (state != FULL) & ~freeze & ~flush, decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (state != EMPTY) & ~freeze.
REQ-018 out_data SHALL always drive the main entry's payload.
REQ-019 in_fire SHALL be defined as in_valid & in_ready; out_fire SHALL be defined as out_valid & out_ready.
REQ-020 In EMPTY, in_fire SHALL load main from in_data and move to ONE.
REQ-021 In ONE, the state update SHALL depend on the fires as follows:
- in_fire only: load skid from in_data, move to FULL.
- out_fire only: move to EMPTY.
- both fires: load main from in_data, stay in ONE.
REQ-022 In FULL, out_fire SHALL copy skid into main and move to ONE; the block SHALL take no input in FULL.
REQ-023 Latency SHALL be one cycle: data accepted at edge N appears on out_data after edge N when the block was EMPTY.
REQ-024 Payload order SHALL be strict FIFO; the block SHALL never drop or duplicate a payload.
REQ-025 Full throughput SHALL be one transfer per cycle whenever out_ready is held high.
REQ-026 While freeze=1 and flush=0, state, main and skid SHALL hold unchanged.
REQ-027 flush=1 SHALL, at the next edge, set state to EMPTY and load main and skid with FLUSH_VAL.
REQ-028 flush SHALL have priority over freeze and over any simultaneous in_valid, which SHALL be discarded.
REQ-029 stall_cnt SHALL increment when out_valid=1 & out_ready=0 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-030 stall_cnt SHALL be unaffected by flush and freeze.
REQ-031 Entries that are not valid SHALL retain their last payload, except as required on flush or reset.

Reset
REQ-032 On reset=1, regardless of clk, the block SHALL immediately set state to EMPTY, main and skid to FLUSH_VAL, and stall_cnt to 0.
REQ-033 With reset=1, outputs SHALL be out_valid=0, in_ready=0, out_data=FLUSH_VAL and stall_cnt=0.
REQ-034 After reset deassertion, in_ready SHALL go high in the same cycle provided freeze=0 and flush=0.
REQ-035 Reset asserted mid-transfer SHALL discard all held payloads with no partial update.

Verification
REQ-036 Streaming: out_ready=1, send payloads 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following cycles; in_ready stays high; stall_cnt=0.
REQ-037 Back-pressure: send A, B with out_ready=0 -> state FULL, in_ready=0, out_data=A, stall_cnt increments each cycle; raise out_ready -> A then B delivered in order.
REQ-038 Flush while FULL with in_valid=1 carrying C -> next cycle out_valid=0, out_data=FLUSH_VAL, and C never appears.
REQ-039 Freeze while ONE holding D, with out_ready=1 and in_valid=1 for 3 cycles -> out_valid=0 and in_ready=0 throughout, D retained; after freeze drops -> D delivered.
REQ-040 Saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and held.
REQ-041 Async reset pulse between clock edges while FULL -> outputs reach reset values before the next edge; in_ready=1 after release.
